// File: rtl/ssd1331_pkg.sv
// rtl/ssd1331_pkg.sv - shared constants and state encoding for the SSD1331 glyph writer
package ssd1331_pkg;

  localparam logic [7:0] CMD_SET_COL = 8'h15;
  localparam logic [7:0] CMD_SET_ROW = 8'h75;

  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 8;
  localparam int DISP_W  = 96;
  localparam int DISP_H  = 64;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_CMD   = 3'd2,
    ST_PIX   = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

endpackage

// File: rtl/ssd1331_char_writer.sv
// rtl/ssd1331_char_writer.sv - draws one 8x8 glyph into an SSD1331 character cell
// Emits column/row window commands then 64 RGB565 pixels over a valid/ready byte stream.
module ssd1331_char_writer
  import ssd1331_pkg::*;
#(
  parameter int DISP_COLS = 12,
  parameter int DISP_ROWS = 8
) (
  input  logic        i_CLK,
  input  logic        i_RST_N,
  input  logic        i_START,
  input  logic [7:0]  i_ASCII,
  input  logic [3:0]  i_COL,
  input  logic [2:0]  i_ROW,
  input  logic [15:0] i_FG,
  input  logic [15:0] i_BG,
  output logic [7:0]  o_FONT_ASCII,
  input  logic [63:0] i_FONT_PIXEL,
  output logic [7:0]  o_TX_DATA,
  output logic        o_TX_DC,
  output logic        o_TX_VALID,
  input  logic        i_TX_READY,
  output logic        o_BUSY,
  output logic        o_DONE,
  output logic        o_ERR
);

  state_t      state;
  logic [3:0]  col_q;
  logic [2:0]  row_q;
  logic [15:0] fg_q;
  logic [15:0] bg_q;
  logic [63:0] glyph;
  logic [2:0]  cmd_idx;
  logic [5:0]  pix_idx;
  logic        half;
  logic        xfer;
  logic        pos_ok;

  assign xfer   = o_TX_VALID & i_TX_READY;
  assign pos_ok = (32'(i_COL) < DISP_COLS) && (32'(i_ROW) < DISP_ROWS);

  function automatic logic [7:0] cmd_byte(input logic [2:0] idx, input logic [3:0] col,
                                          input logic [2:0] row);
    logic [7:0] c8;
    logic [7:0] r8;
    c8 = 8'(col) << 3;
    r8 = 8'(row) << 3;
    case (idx)
      3'd0:    return CMD_SET_COL;
      3'd1:    return c8;
      3'd2:    return c8 | 8'(GLYPH_W - 1);
      3'd3:    return CMD_SET_ROW;
      3'd4:    return r8;
      default: return r8 | 8'(GLYPH_H - 1);
    endcase
  endfunction

  // Pixel 0 is glyph bit 63 (top-left); colour goes out high byte first.
  function automatic logic [7:0] pix_byte(input logic [63:0] g, input logic [5:0] p,
                                          input logic h, input logic [15:0] fg,
                                          input logic [15:0] bg);
    logic [15:0] colour;
    colour = g[6'd63 - p] ? fg : bg;
    return h ? colour[7:0] : colour[15:8];
  endfunction

  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      state        <= ST_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      fg_q         <= '0;
      bg_q         <= '0;
      glyph        <= '0;
      cmd_idx      <= '0;
      pix_idx      <= '0;
      half         <= 1'b0;
      o_FONT_ASCII <= '0;
      o_TX_DATA    <= '0;
      o_TX_DC      <= 1'b0;
      o_TX_VALID   <= 1'b0;
      o_BUSY       <= 1'b0;
      o_DONE       <= 1'b0;
      o_ERR        <= 1'b0;
    end else begin
      o_DONE <= 1'b0;
      o_ERR  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_START) begin
            if (pos_ok) begin
              o_FONT_ASCII <= i_ASCII;
              col_q        <= i_COL;
              row_q        <= i_ROW;
              fg_q         <= i_FG;
              bg_q         <= i_BG;
              o_BUSY       <= 1'b1;
              state        <= ST_LATCH;
            end else begin
              o_ERR <= 1'b1;
            end
          end
        end
        ST_LATCH: begin
          glyph      <= i_FONT_PIXEL;
          cmd_idx    <= '0;
          o_TX_DATA  <= cmd_byte(3'd0, col_q, row_q);
          o_TX_DC    <= 1'b0;
          o_TX_VALID <= 1'b1;
          state      <= ST_CMD;
        end
        ST_CMD: begin
          if (xfer) begin
            if (cmd_idx == 3'd5) begin
              pix_idx   <= '0;
              half      <= 1'b0;
              o_TX_DATA <= pix_byte(glyph, 6'd0, 1'b0, fg_q, bg_q);
              o_TX_DC   <= 1'b1;
              state     <= ST_PIX;
            end else begin
              cmd_idx   <= cmd_idx + 3'd1;
              o_TX_DATA <= cmd_byte(cmd_idx + 3'd1, col_q, row_q);
            end
          end
        end
        ST_PIX: begin
          if (xfer) begin
            if (pix_idx == 6'd63 && half) begin
              pix_idx    <= '0;
              half       <= 1'b0;
              o_TX_DATA  <= '0;
              o_TX_DC    <= 1'b0;
              o_TX_VALID <= 1'b0;
              o_DONE     <= 1'b1;
              state      <= ST_FIN;
            end else if (!half) begin
              half      <= 1'b1;
              o_TX_DATA <= pix_byte(glyph, pix_idx, 1'b1, fg_q, bg_q);
            end else begin
              half      <= 1'b0;
              pix_idx   <= pix_idx + 6'd1;
              o_TX_DATA <= pix_byte(glyph, pix_idx + 6'd1, 1'b0, fg_q, bg_q);
            end
          end
        end
        ST_FIN: begin
          o_BUSY <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ssd1331_char_writer.sv
// tb/tb_ssd1331_char_writer.sv - directed self-checking bench for ssd1331_char_writer
module tb_ssd1331_char_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  ascii = '0;
  logic [3:0]  col = '0;
  logic [2:0]  row = '0;
  logic [15:0] fg = '0;
  logic [15:0] bg = '0;
  logic [7:0]  font_ascii;
  logic [63:0] font_pixel;
  logic [7:0]  tx_data;
  logic        tx_dc;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        busy;
  logic        done;
  logic        err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ready_mode = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] font_rom(input logic [7:0] c);
    case (c)
      8'h41:   return 64'h3078CCCCFCCCCC00;
      8'h42:   return 64'hFC66667C6666FC00;
      default: return 64'h0;
    endcase
  endfunction

  assign font_pixel = font_rom(font_ascii);

  ssd1331_char_writer #(.DISP_COLS(12), .DISP_ROWS(8)) dut (
    .i_CLK(clk), .i_RST_N(rst_n), .i_START(start), .i_ASCII(ascii),
    .i_COL(col), .i_ROW(row), .i_FG(fg), .i_BG(bg),
    .o_FONT_ASCII(font_ascii), .i_FONT_PIXEL(font_pixel),
    .o_TX_DATA(tx_data), .o_TX_DC(tx_dc), .o_TX_VALID(tx_valid), .i_TX_READY(tx_ready),
    .o_BUSY(busy), .o_DONE(done), .o_ERR(err)
  );

  // Ready generator: constant high, or the repeating 1,0,0,1 stall pattern.
  initial begin
    int ph = 0;
    logic [3:0] pat = 4'b1001;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) tx_ready = 1'b1;
      else begin
        tx_ready = pat[3 - ph];
        ph = (ph + 1) % 4;
      end
    end
  end

  logic [7:0] q_data[$];
  logic       q_dc[$];
  logic [7:0] exp_data[$];
  logic       exp_dc[$];
  int done_cnt, err_cnt, stall_viol, first_cyc, last_cyc, done_cyc;
  bit valid_seen, hold_pending;
  logic [7:0] held_data;
  logic       held_dc;

  always @(negedge clk) begin
    if (hold_pending && (!tx_valid || tx_data !== held_data || tx_dc !== held_dc))
      stall_viol++;
    hold_pending = tx_valid && !tx_ready;
    held_data = tx_data;
    held_dc = tx_dc;
    if (tx_valid) valid_seen = 1'b1;
    if (tx_valid && tx_ready) begin
      q_data.push_back(tx_data);
      q_dc.push_back(tx_dc);
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (err) err_cnt++;
  end

  task automatic clear_mon();
    q_data.delete(); q_dc.delete();
    done_cnt = 0; err_cnt = 0; stall_viol = 0;
    first_cyc = -1; last_cyc = -1; done_cyc = -1;
    valid_seen = 1'b0; hold_pending = 1'b0;
  endtask

  task automatic build_exp(input logic [7:0] ch, input logic [3:0] c, input logic [2:0] r,
                           input logic [15:0] f, input logic [15:0] b);
    logic [63:0] g;
    logic [7:0]  rb;
    logic [15:0] colr;
    exp_data.delete(); exp_dc.delete();
    exp_data.push_back(8'h15); exp_data.push_back(8'(c * 8)); exp_data.push_back(8'(c * 8 + 7));
    exp_data.push_back(8'h75); exp_data.push_back(8'(r * 8)); exp_data.push_back(8'(r * 8 + 7));
    for (int i = 0; i < 6; i++) exp_dc.push_back(1'b0);
    g = font_rom(ch);
    for (int y = 0; y < 8; y++) begin
      rb = g[63 - 8 * y -: 8];
      for (int x = 0; x < 8; x++) begin
        colr = rb[7 - x] ? f : b;
        exp_data.push_back(colr[15:8]); exp_dc.push_back(1'b1);
        exp_data.push_back(colr[7:0]);  exp_dc.push_back(1'b1);
      end
    end
  endtask

  function automatic int first_mismatch();
    int n = (q_data.size() > exp_data.size()) ? q_data.size() : exp_data.size();
    for (int i = 0; i < n; i++)
      if (i >= q_data.size() || i >= exp_data.size() ||
          q_data[i] !== exp_data[i] || q_dc[i] !== exp_dc[i]) return i;
    return -1;
  endfunction

  // Pulses start for one edge (edge 0) and returns at the negedge of cycle 1.
  task automatic start_op(input logic [7:0] ch, input logic [3:0] c, input logic [2:0] r,
                          input logic [15:0] f, input logic [15:0] b, output int base);
    @(posedge clk); #1;
    clear_mon();
    ascii = ch; col = c; row = r; fg = f; bg = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ascii = 8'h42; col = 4'd9; row = 3'd6; fg = 16'hAAAA; bg = 16'h5555;
    @(negedge clk);
    base = cyc;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    if (done_cnt == 0) begin
      $display("FAIL %s_timeout: no done within %0d cycles, got 0 required 1", name, budget);
      errors++; checks++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({font_ascii, tx_data, tx_dc, tx_valid, busy, done, err} !== 21'd0) begin
      $display("FAIL reset_outputs: got %h required 0",
               {font_ascii, tx_data, tx_dc, tx_valid, busy, done, err});
      errors++;
    end
  endtask

  task automatic test_glyph_a();
    int base, mm, rel;
    logic [7:0] cmd_k [6] = '{8'h15, 8'h10, 8'h17, 8'h75, 8'h08, 8'h0F};
    logic [7:0] pix_k [10] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hF8, 8'h00, 8'hF8, 8'h00, 8'h00, 8'h00};
    ready_mode = 0;
    build_exp(8'h41, 4'd2, 3'd1, 16'hF800, 16'h0000);
    start_op(8'h41, 4'd2, 3'd1, 16'hF800, 16'h0000, base);
    checks++;
    if (font_ascii !== 8'h41 || busy !== 1'b1) begin
      $display("FAIL a_latch: got font=%h busy=%b required 41/1", font_ascii, busy);
      errors++;
    end
    wait_done(400, "a");
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (q_data.size() <= i || q_data[i] !== cmd_k[i] || q_dc[i] !== 1'b0) begin
        $display("FAIL a_cmd%0d: got %h required %h dc=0", i,
                 (q_data.size() > i) ? q_data[i] : 8'hxx, cmd_k[i]);
        errors++;
      end
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (q_data.size() <= i + 6 || q_data[i + 6] !== pix_k[i] || q_dc[i + 6] !== 1'b1) begin
        $display("FAIL a_pix%0d: got %h required %h dc=1", i,
                 (q_data.size() > i + 6) ? q_data[i + 6] : 8'hxx, pix_k[i]);
        errors++;
      end
    end
    mm = first_mismatch();
    checks++;
    if (mm !== -1) begin
      $display("FAIL a_stream: first difference at byte %0d, got %0d bytes required 134", mm, q_data.size());
      errors++;
    end
    rel = first_cyc - base + 1;
    checks++;
    if (rel !== 2) begin $display("FAIL a_first_cycle: got %0d required 2", rel); errors++; end
    rel = last_cyc - base + 1;
    checks++;
    if (rel !== 135) begin $display("FAIL a_last_cycle: got %0d required 135", rel); errors++; end
    rel = done_cyc - base + 1;
    checks++;
    if (rel !== 136 || done_cnt !== 1) begin
      $display("FAIL a_done: got cycle %0d count %0d required 136/1", rel, done_cnt);
      errors++;
    end
    checks++;
    if (busy !== 1'b0) begin $display("FAIL a_idle_busy: got %b required 0", busy); errors++; end
  endtask

  task automatic test_space_corner();
    int base, bad;
    logic [7:0] cmd_k [6] = '{8'h15, 8'h58, 8'h5F, 8'h75, 8'h38, 8'h3F};
    ready_mode = 0;
    start_op(8'h20, 4'd11, 3'd7, 16'hFFFF, 16'h1234, base);
    wait_done(400, "space");
    checks++;
    if (q_data.size() !== 134) begin
      $display("FAIL space_count: got %0d required 134", q_data.size()); errors++;
    end
    bad = 0;
    for (int i = 0; i < 6; i++)
      if (q_data.size() <= i || q_data[i] !== cmd_k[i] || q_dc[i] !== 1'b0) bad++;
    checks++;
    if (bad !== 0) begin $display("FAIL space_cmd: got %0d bad bytes required 0", bad); errors++; end
    bad = 0;
    for (int i = 6; i < 134; i++)
      if (q_data.size() <= i || q_data[i] !== ((i % 2 == 0) ? 8'h12 : 8'h34) || q_dc[i] !== 1'b1) bad++;
    checks++;
    if (bad !== 0) begin $display("FAIL space_pix: got %0d bad bytes required 0", bad); errors++; end
  endtask

  task automatic test_backpressure();
    int base, mm, rel;
    ready_mode = 1;
    build_exp(8'h41, 4'd2, 3'd1, 16'hF800, 16'h0000);
    start_op(8'h41, 4'd2, 3'd1, 16'hF800, 16'h0000, base);
    wait_done(1000, "bp");
    ready_mode = 0;
    mm = first_mismatch();
    checks++;
    if (mm !== -1) begin
      $display("FAIL bp_stream: first difference at byte %0d, got %0d bytes required 134", mm, q_data.size());
      errors++;
    end
    checks++;
    if (stall_viol !== 0) begin $display("FAIL bp_stable: got %0d violations required 0", stall_viol); errors++; end
    checks++;
    if (done_cnt !== 1) begin $display("FAIL bp_done: got %0d required 1", done_cnt); errors++; end
    rel = last_cyc - base + 1;
    checks++;
    if (rel <= 135) begin $display("FAIL bp_stalled: got last cycle %0d required >135", rel); errors++; end
  endtask

  task automatic test_out_of_range();
    int base, mm;
    start_op(8'h41, 4'd12, 3'd0, 16'hF800, 16'h0000, base);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || tx_valid !== 1'b0) begin
      $display("FAIL oor_pulse: got err=%b busy=%b valid=%b required 1/0/0", err, busy, tx_valid);
      errors++;
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin $display("FAIL oor_width: got %b required 0", err); errors++; end
    start_op(8'h41, 4'd15, 3'd3, 16'hF800, 16'h0000, base);
    repeat (6) @(negedge clk);
    checks++;
    if (err_cnt !== 1 || valid_seen !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL oor_col15: got err_cnt=%0d valid_seen=%b busy=%b required 1/0/0", err_cnt, valid_seen, busy);
      errors++;
    end
    build_exp(8'h41, 4'd0, 3'd0, 16'h07E0, 16'h001F);
    start_op(8'h41, 4'd0, 3'd0, 16'h07E0, 16'h001F, base);
    wait_done(400, "oor_follow");
    mm = first_mismatch();
    checks++;
    if (mm !== -1 || done_cnt !== 1) begin
      $display("FAIL oor_follow: got mismatch at %0d done=%0d required -1/1", mm, done_cnt);
      errors++;
    end
  endtask

  task automatic test_start_while_busy();
    int base, mm;
    build_exp(8'h41, 4'd5, 3'd4, 16'hFFE0, 16'h0010);
    start_op(8'h41, 4'd5, 3'd4, 16'hFFE0, 16'h0010, base);
    repeat (20) @(negedge clk);
    @(posedge clk); #1;
    ascii = 8'h42; col = 4'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (font_ascii !== 8'h41) begin $display("FAIL busy_font: got %h required 41", font_ascii); errors++; end
    wait_done(400, "busy");
    mm = first_mismatch();
    checks++;
    if (mm !== -1 || done_cnt !== 1) begin
      $display("FAIL busy_stream: got mismatch at %0d done=%0d required -1/1", mm, done_cnt);
      errors++;
    end
    clear_mon();
    repeat (6) @(negedge clk);
    checks++;
    if (valid_seen !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL busy_no_replay: got valid_seen=%b busy=%b required 0/0", valid_seen, busy);
      errors++;
    end
  endtask

  task automatic test_mid_reset();
    int base, n, mm;
    start_op(8'h41, 4'd3, 3'd2, 16'hF800, 16'h0000, base);
    n = 0;
    while (q_data.size() < 40 && n < 400) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({font_ascii, tx_data, tx_dc, tx_valid, busy, done, err} !== 21'd0) begin
      $display("FAIL midrst_outputs: got %h required 0",
               {font_ascii, tx_data, tx_dc, tx_valid, busy, done, err});
      errors++;
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      $display("FAIL midrst_idle: got busy=%b valid=%b required 0/0", busy, tx_valid); errors++;
    end
    build_exp(8'h41, 4'd3, 3'd2, 16'hF800, 16'h0000);
    start_op(8'h41, 4'd3, 3'd2, 16'hF800, 16'h0000, base);
    wait_done(400, "midrst");
    mm = first_mismatch();
    checks++;
    if (mm !== -1 || done_cnt !== 1) begin
      $display("FAIL midrst_restart: got mismatch at %0d done=%0d required -1/1", mm, done_cnt);
      errors++;
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_glyph_a();
    test_space_corner();
    test_backpressure();
    test_out_of_range();
    test_start_while_busy();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ssd1331_char_writer.md
Name: ssd1331_char_writer

Overview:
Renders one 8x8 text glyph into a character cell of the 96x64 SSD1331 OLED. It drives the ASCII font ROM lookup and registers the returned 64-bit bitmap. It then emits the SSD1331 window-address command bytes, followed by 64 RGB565 pixels, as a byte stream with a D/C flag. The downstream SPI byte transmitter consumes the stream over a valid/ready handshake.

Parameters:
DISP_COLS, 12, number of character columns (96 px / 8)
DISP_ROWS, 8, number of character rows (64 px / 8)

Ports:
i_CLK  in  1  system clock
i_RST_N  in  1  synchronous active-low reset
i_START  in  1  request pulse; sampled only in IDLE
i_ASCII  in  8  character code to draw
i_COL  in  4  character column, 0..DISP_COLS-1
i_ROW  in  3  character row, 0..DISP_ROWS-1
i_FG  in  16  RGB565 colour for set pixels
i_BG  in  16  RGB565 colour for clear pixels
o_FONT_ASCII  out  8  code presented to font ROM (registered copy of i_ASCII)
i_FONT_PIXEL  in  64  bitmap from font ROM; bit 63 = top-left pixel, row-major, MSB of each byte is leftmost
o_TX_DATA  out  8  byte to transmitter
o_TX_DC  out  1  0 = command byte, 1 = pixel data byte
o_TX_VALID  out  1  byte valid
i_TX_READY  in  1  transmitter accepts byte
o_BUSY  out  1  high in every state except IDLE
o_DONE  out  1  one-cycle pulse after the last byte is accepted
o_ERR  out  1  one-cycle pulse when a start is rejected for out-of-range position

Behaviour:
- Clock and reset: single clock i_CLK. Reset is synchronous, active-low on i_RST_N; polarity and synchronicity are fixed.
- Reset values: all outputs 0. State IDLE, all counters 0.
- Reset mid-operation: all outputs are 0 on the cycle after reset is sampled low, and the state returns to IDLE. o_TX_VALID drops even without a handshake; this is the only exception to the valid-hold rule.
- States: IDLE, LATCH, CMD, PIX, FIN.
- IDLE:
  - i_START=1 with i_COL<DISP_COLS and i_ROW<DISP_ROWS: capture i_ASCII, i_COL, i_ROW, i_FG, i_BG; go to LATCH.
  - i_START=1 with either position out of range: pulse o_ERR next cycle, stay in IDLE, emit no bytes.
- Start in any state other than IDLE: ignored, with no side effects.
- LATCH (1 cycle): o_FONT_ASCII holds the captured code. i_FONT_PIXEL (combinational ROM) is registered at the end of the cycle. Go to CMD with cmd_idx=0.
- CMD: six bytes, DC=0, in this order:
  - 0x15, COL*8, COL*8+7
  - 0x75, ROW*8, ROW*8+7
  - After the handshake on cmd_idx=5, go to PIX with pix_idx=0, half=0.
- PIX: DC=1. For each pixel p=0..63, bit = glyph[63-p].
  - Colour = bit ? FG : BG.
  - half=0 sends colour[15:8]; half=1 sends colour[7:0].
  - 128 bytes total. After the handshake on p=63, half=1, go to FIN.
- FIN (1 cycle): o_DONE=1, o_BUSY=1, then go to IDLE.
- Handshake:
  - A byte transfers on any cycle with o_TX_VALID & i_TX_READY.
  - o_TX_VALID is high throughout CMD and PIX.
  - o_TX_DATA and o_TX_DC are stable while valid is high and not yet accepted.
  - Counters advance only on a transfer.
  - One byte per cycle maximum when ready is held high.
- Latency: if i_START is sampled at edge 0, LATCH is cycle 1 and bytes are valid in cycles 2..135 with ready held high. o_DONE is in cycle 136, and a new start is accepted from cycle 137.
- Arithmetic: COL*8 and ROW*8 are built by shift, zero-extended to 8 bits. The maximum window end is col 95, row 63.
- Inputs i_COL, i_ROW, i_FG, i_BG and i_ASCII may change freely after capture; only the captured copies are used.

Decomposition:
- Package ssd1331_pkg holds:
  - CMD_SET_COL=8'h15, CMD_SET_ROW=8'h75
  - GLYPH_W=8, GLYPH_H=8, DISP_W=96, DISP_H=64
  - State enum
- The font ROM is instantiated by the parent and connected through o_FONT_ASCII/i_FONT_PIXEL.
- No sub-module: the FSM, counters and byte mux form one block.

Test Plan:
1. 'A' (0x41), col 2, row 1, FG=0xF800, BG=0x0000, ready held high -> command bytes 15 10 17 75 08 0F with DC=0. Pixel bytes begin 00 00 00 00 F8 00 F8 00 00 00 (row 0 = 0x30 after bit order). 134 transfers in cycles 2..135, o_DONE in cycle 136.
2. Space (0x20), col 11, row 7, BG=0x1234 -> commands 15 58 5F 75 38 3F, then 64 repetitions of 12 34, all with DC=1.
3. Same as 1 with i_TX_READY toggling 1,0,0,1 repeatedly -> byte sequence identical to 1, data/DC stable during stalls, exactly 134 transfers, o_DONE once.
4. i_START with i_COL=12 (or any col 12..15) -> o_ERR pulse next cycle, o_BUSY stays 0, o_TX_VALID never asserts. A following valid start works normally.
5. Second i_START while busy, with a different ASCII -> ignored: byte stream and o_FONT_ASCII unchanged, single o_DONE.
6. i_RST_N low for 1 cycle after the 40th transfer -> next cycle all outputs 0 and state IDLE. A new start then produces the full sequence beginning with 0x15.
